// File: rtl/dma_block_mover.sv
// ============================================================================
// dma_block_mover : block-copy DMA master staging each word through fifo_reg
// Rev 1.0
// ============================================================================
`default_nettype none

module dma_block_mover #(
  parameter int CNT_W   = 8,
  parameter int SRC_INC = 1,
  parameter int DST_INC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [15:0]      src_addr_i,
  input  logic [15:0]      dst_addr_i,
  input  logic [CNT_W-1:0] word_cnt_i,
  input  logic             prio_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [14:0]      dma_addr_o,
  output logic [15:0]      dma_din_o,
  output logic             dma_en_o,
  output logic [1:0]       dma_we_o,
  output logic             dma_priority_o,
  output logic             dma_wkup_o,
  input  logic [15:0]      dma_dout_i,
  input  logic             dma_ready_i,
  input  logic             dma_resp_i,
  output logic             fifo_en_o,
  output logic             fifo_wr_rd_o,
  output logic [15:0]      fifo_din_o,
  input  logic [15:0]      fifo_dout_i,
  input  logic             fifo_flag_i
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD_REQ  = 4'd1,
    S_RD_DATA = 4'd2,
    S_BUF_WR  = 4'd3,
    S_BUF_CHK = 4'd4,
    S_BUF_RD  = 4'd5,
    S_WR_REQ  = 4'd6,
    S_WR_RESP = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  localparam logic [15:0]      C_SRC_STEP = (SRC_INC != 0) ? 16'd2 : 16'd0;
  localparam logic [15:0]      C_DST_STEP = (DST_INC != 0) ? 16'd2 : 16'd0;
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic [15:0]      src_q, dst_q;
  logic [CNT_W-1:0] cnt_q;
  logic             prio_q, error_q, done_q;
  logic [14:0]      dma_addr_q;
  logic [15:0]      dma_din_q, fifo_din_q;
  logic             dma_en_q, fifo_en_q, fifo_wr_rd_q;
  logic [1:0]       dma_we_q;

  logic [15:0]      src_d, dst_d;
  logic [CNT_W-1:0] cnt_d;

  assign src_d = src_q + C_SRC_STEP;
  assign dst_d = dst_q + C_DST_STEP;
  assign cnt_d = cnt_q - C_CNT_ONE;

  // Every bus/buffer output is registered and only asserted on entry to its state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      cnt_q        <= '0;
      prio_q       <= 1'b0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
      dma_addr_q   <= '0;
      dma_din_q    <= '0;
      dma_en_q     <= 1'b0;
      dma_we_q     <= 2'b00;
      fifo_en_q    <= 1'b0;
      fifo_wr_rd_q <= 1'b0;
      fifo_din_q   <= '0;
    end else begin
      done_q       <= 1'b0;
      dma_en_q     <= 1'b0;
      dma_we_q     <= 2'b00;
      dma_addr_q   <= '0;
      fifo_en_q    <= 1'b0;
      fifo_wr_rd_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            src_q   <= src_addr_i;
            dst_q   <= dst_addr_i;
            cnt_q   <= word_cnt_i;
            prio_q  <= prio_i;
            error_q <= 1'b0;
            if (word_cnt_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_RD_REQ;
              dma_en_q   <= 1'b1;
              dma_addr_q <= src_addr_i[15:1];
            end
          end
        end
        S_RD_REQ: begin
          if (dma_ready_i) begin
            state_q <= S_RD_DATA;
          end else begin
            dma_en_q   <= 1'b1;
            dma_addr_q <= src_q[15:1];
          end
        end
        S_RD_DATA: begin
          if (dma_resp_i) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            fifo_din_q   <= dma_dout_i;
            fifo_en_q    <= 1'b1;
            fifo_wr_rd_q <= 1'b1;
            state_q      <= S_BUF_WR;
          end
        end
        S_BUF_WR: state_q <= S_BUF_CHK;
        S_BUF_CHK: begin
          if (!fifo_flag_i) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            fifo_en_q <= 1'b1;
            state_q   <= S_BUF_RD;
          end
        end
        S_BUF_RD: begin
          dma_din_q  <= fifo_dout_i;
          dma_en_q   <= 1'b1;
          dma_we_q   <= 2'b11;
          dma_addr_q <= dst_q[15:1];
          state_q    <= S_WR_REQ;
        end
        S_WR_REQ: begin
          if (dma_ready_i) begin
            state_q <= S_WR_RESP;
          end else begin
            dma_en_q   <= 1'b1;
            dma_we_q   <= 2'b11;
            dma_addr_q <= dst_q[15:1];
          end
        end
        S_WR_RESP: begin
          if (dma_resp_i) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
            src_q <= src_d;
            dst_q <= dst_d;
            if (cnt_q == C_CNT_ONE) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              dma_en_q   <= 1'b1;
              dma_addr_q <= src_d[15:1];
              state_q    <= S_RD_REQ;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign dma_addr_o     = dma_addr_q;
  assign dma_din_o      = dma_din_q;
  assign dma_en_o       = dma_en_q;
  assign dma_we_o       = dma_we_q;
  assign dma_priority_o = prio_q;
  assign dma_wkup_o     = busy_o;
  assign fifo_en_o      = fifo_en_q;
  assign fifo_wr_rd_o   = fifo_wr_rd_q;
  assign fifo_din_o     = fifo_din_q;

endmodule

`default_nettype wire
